// File: rtl/rx_iq_packer_if.sv
// rx_iq_packer_if: packed-word valid/ready stream toward the host FIFO writer.
// Signals: out_data (word), out_valid (word present), out_ready (consumer accepts).
interface rx_iq_packer_if;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/rx_iq_packer.sv
// rx_iq_packer: drains 24-bit IQ pairs from the RX FIFO (1-cycle read latency)
// and packs them LSB-first, no padding, into 32-bit words (4 pairs -> 3 words).
// Ports: clk, reset_n (sync, active-low), en (read permit), flush (pulse),
//   fifo_empty/fifo_data/fifo_req (RX FIFO side), busy,
//   stream (rx_iq_packer_if.master: out_data/out_valid/out_ready).
// Build option: define RX_IQ_PACKER_FLUSH_EN to compile in the flush logic;
//   without it the flush port is ignored.
module rx_iq_packer (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [23:0]          fifo_data,
  output logic                 fifo_req,
  output logic                 busy,
  rx_iq_packer_if.master       stream
);

  localparam int IQ_PAIR_WIDTH = 24;
  localparam int OUT_WIDTH     = 32;

  logic                     rd_pend;
  logic [1:0]               phase;
  logic [IQ_PAIR_WIDTH-1:0] res;
  logic [1:0]               occ;
  logic [OUT_WIDTH-1:0]     ent0;
  logic [OUT_WIDTH-1:0]     ent1;
  logic                     flush_pend;

  logic                     pop;
  logic [2:0]               occ_net;
  logic                     fl_blk;
  logic                     fl_push;
  logic                     fl_done;

  logic                     cap_push;
  logic [OUT_WIDTH-1:0]     cap_word;
  logic [IQ_PAIR_WIDTH-1:0] res_nxt;
  logic [1:0]               phase_nxt;

  logic                     push;
  logic [OUT_WIDTH-1:0]     word;

  assign pop     = stream.out_valid & stream.out_ready;
  assign occ_net = {1'b0, occ} - {2'b0, pop};

  // A pulse in the same cycle already blocks reads, so no extra read
  // slips in ahead of the flush word.
  assign fifo_req = reset_n & en & ~fifo_empty & ~fl_blk &
                    ((occ_net + {2'b0, rd_pend}) < 3'd2);

`ifdef RX_IQ_PACKER_FLUSH_EN
  logic fl_go;

  assign fl_blk  = flush | flush_pend;
  assign fl_go   = fl_blk & ~rd_pend;
  assign fl_push = fl_go & (phase != 2'd0) & (occ_net < 3'd2);
  assign fl_done = fl_go & ((phase == 2'd0) | (occ_net < 3'd2));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else if (fl_done) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign fl_blk       = 1'b0;
  assign fl_push      = 1'b0;
  assign fl_done      = 1'b0;
  assign flush_pend   = 1'b0;
`endif

  // Residual is kept right-aligned with zero upper bits, so the flush
  // word is simply the residual zero-extended.
  always_comb begin
    cap_push  = 1'b0;
    cap_word  = '0;
    res_nxt   = res;
    phase_nxt = phase;
    if (rd_pend) begin
      phase_nxt = phase + 2'd1;
      unique case (phase)
        2'd0: begin
          res_nxt = fifo_data;
        end
        2'd1: begin
          cap_push = 1'b1;
          cap_word = {fifo_data[7:0], res[23:0]};
          res_nxt  = {8'b0, fifo_data[23:8]};
        end
        2'd2: begin
          cap_push = 1'b1;
          cap_word = {fifo_data[15:0], res[15:0]};
          res_nxt  = {16'b0, fifo_data[23:16]};
        end
        2'd3: begin
          cap_push = 1'b1;
          cap_word = {fifo_data, res[7:0]};
          res_nxt  = '0;
        end
        default: ;
      endcase
    end
  end

  assign push = cap_push | fl_push;
  assign word = cap_push ? cap_word : {8'b0, res};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      phase   <= 2'd0;
      res     <= '0;
    end else begin
      rd_pend <= fifo_req;
      if (fl_push) begin
        phase <= 2'd0;
        res   <= '0;
      end else begin
        phase <= phase_nxt;
        res   <= res_nxt;
      end
    end
  end

  // Two-entry output buffer; ent0 is the head and only moves on a pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= word;
          else             ent1 <= word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= word;
          end else begin
            ent0 <= ent1;
            ent1 <= word;
          end
        end
        default: ;
      endcase
    end
  end

  assign stream.out_valid = (occ != 2'd0);
  assign stream.out_data  = ent0;

  assign busy = (phase != 2'd0) | (occ != 2'd0) | rd_pend | flush_pend;

endmodule

// File: tb/tb_rx_iq_packer.sv
// tb_rx_iq_packer: directed + reference-model bench for rx_iq_packer.
// Models the RX FIFO with a queue; collects accepted words at negedge.
module tb_rx_iq_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        flush;
  logic        fifo_empty;
  logic [23:0] fifo_data = '0;
  logic        fifo_req;
  logic        busy;

  rx_iq_packer_if ifc ();

  rx_iq_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_req   (fifo_req),
    .busy       (busy),
    .stream     (ifc)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] src_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          viol = 0;
  int          bad_pop = 0;
  int          run = 0;
  int          maxrun = 0;
  logic        empty_mask = 1'b0;
  logic        tog = 1'b0;
  logic [63:0] racc;
  int          rcnt;

  always @(posedge clk) begin
    if (fifo_req) begin
      if (src_q.size() == 0) bad_pop++;
      else fifo_data <= src_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (fifo_req && fifo_empty) viol++;
    if (fifo_req) begin
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    if (ifc.out_valid && ifc.out_ready) got_q.push_back(ifc.out_data);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (src_q.size() == 0) || empty_mask;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (tog) empty_mask = ~empty_mask;
    upd_empty();
  endtask

  task automatic cycles(int n);
    repeat (n) cyc();
  endtask

  task automatic load(logic [23:0] p);
    src_q.push_back(p);
    upd_empty();
  endtask

  task automatic load_abcd();
    load(24'h111111);
    load(24'h222222);
    load(24'h333333);
    load(24'h444444);
  endtask

  function automatic logic [31:0] getw(int i);
    if (i < got_q.size()) return got_q[i];
    return 32'hdeadbeef;
  endfunction

  task automatic drain(string tag, int n, int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, 32'(got_q.size()), 32'(n));
  endtask

  task automatic chk_abcd(string tag);
    chk({tag, "_w0"}, getw(0), 32'h22111111);
    chk({tag, "_w1"}, getw(1), 32'h33332222);
    chk({tag, "_w2"}, getw(2), 32'h44444433);
  endtask

  task automatic ref_add(logic [23:0] p);
    racc = racc | (64'(p) << rcnt);
    rcnt += 24;
    if (rcnt >= 32) begin
      exp_q.push_back(racc[31:0]);
      racc = racc >> 32;
      rcnt -= 32;
    end
  endtask

  initial begin
    int errs;
    int k;
    logic [23:0] p;

    // reset state, with data waiting and reads enabled
    reset_n = 1'b0;
    en = 1'b1;
    flush = 1'b0;
    ifc.out_ready = 1'b1;
    upd_empty();
    load_abcd();
    cycles(3);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_data", ifc.out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(fifo_req), 32'd0);

    // basic stream, ready high
    got_q.delete();
    maxrun = 0;
    reset_n = 1'b1;
    drain("a_cnt", 3, 50);
    chk_abcd("a");
    chk("a_reqrun", 32'(maxrun), 32'd4);
    cycles(3);
    chk("a_busy", 32'(busy), 32'd0);

    // backpressure: two words buffered, reads stall
    got_q.delete();
    ifc.out_ready = 1'b0;
    load_abcd();
    cycles(8);
    chk("b_nopop", 32'(got_q.size()), 32'd0);
    chk("b_left", 32'(src_q.size()), 32'd1);
    chk("b_valid", 32'(ifc.out_valid), 32'd1);
    chk("b_head", ifc.out_data, 32'h22111111);
    chk("b_req", 32'(fifo_req), 32'd0);
    cycles(3);
    chk("b_hold", ifc.out_data, 32'h22111111);
    ifc.out_ready = 1'b1;
    drain("b_cnt", 3, 50);
    chk_abcd("b");
    cycles(3);
    chk("b_dup", 32'(got_q.size()), 32'd3);

`ifdef RX_IQ_PACKER_FLUSH_EN
    got_q.delete();
    load(24'habcdef);
    cycles(4);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("f1_lat", 32'(ifc.out_valid), 32'd1);
    drain("f1_cnt", 1, 20);
    chk("f1_w0", getw(0), 32'h00abcdef);
    cycles(2);
    chk("f1_busy", 32'(busy), 32'd0);

    got_q.delete();
    load(24'habcdef);
    load(24'h123456);
    cycles(5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain("f2_cnt", 2, 20);
    chk("f2_w0", getw(0), 32'h56abcdef);
    chk("f2_w1", getw(1), 32'h00001234);
    cycles(2);
    chk("f2_busy", 32'(busy), 32'd0);
`else
    got_q.delete();
    load(24'habcdef);
    cycles(4);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cycles(5);
    chk("nf_cnt", 32'(got_q.size()), 32'd0);
    chk("nf_busy", 32'(busy), 32'd1);
    load(24'h222222);
    load(24'h333333);
    load(24'h444444);
    drain("nf_cnt2", 3, 50);
    chk("nf_w0", getw(0), 32'h22abcdef);
    chk("nf_w1", getw(1), 32'h33332222);
    chk("nf_w2", getw(2), 32'h44444433);
`endif

    // random pairs, empty toggling, random backpressure
    cycles(3);
    got_q.delete();
    exp_q.delete();
    racc = '0;
    rcnt = 0;
    for (int i = 0; i < 400; i++) begin
      p = 24'($urandom);
      load(p);
      ref_add(p);
    end
    tog = 1'b1;
    k = 0;
    while (got_q.size() < 300 && k < 5000) begin
      ifc.out_ready = 1'($urandom_range(0, 1));
      cyc();
      k++;
    end
    tog = 1'b0;
    empty_mask = 1'b0;
    ifc.out_ready = 1'b1;
    cycles(3);
    chk("r_cnt", 32'(got_q.size()), 32'(exp_q.size()));
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (getw(i) !== exp_q[i]) errs++;
    end
    chk("r_words", 32'(errs), 32'd0);

    // reset mid-stream
    got_q.delete();
    ifc.out_ready = 1'b0;
    load(24'h111111);
    load(24'h222222);
    cycles(5);
    chk("rs_pre", 32'(ifc.out_valid), 32'd1);
    reset_n = 1'b0;
    cyc();
    chk("rs_valid", 32'(ifc.out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    ifc.out_ready = 1'b1;
    load_abcd();
    drain("rs_cnt", 3, 50);
    chk_abcd("rs");

    // en gap between pair 1 and pair 2
    cycles(3);
    got_q.delete();
    en = 1'b0;
    load_abcd();
    cyc();
    en = 1'b1;
    cyc();
    en = 1'b0;
    cycles(10);
    chk("e_left", 32'(src_q.size()), 32'd3);
    chk("e_busy", 32'(busy), 32'd1);
    en = 1'b1;
    drain("e_cnt", 3, 50);
    chk_abcd("e");

    chk("req_empty", 32'(viol), 32'd0);
    chk("bad_pop", 32'(bad_pop), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
